// File: rtl/msu_pkg.sv
// Shared sizing constants for the squarer reduction path, plus constant
// functions that describe the geometry of a radix-N reduction tree.
package msu_pkg;

  localparam int TreeBits   = 8;
  localparam int SqSumBits  = 16;
  localparam int SqGridRows = 16;

  // Number of radix-wide reduction levels needed to fold n operands into one.
  function automatic int tree_levels(input int n, input int radix);
    int lv;
    int cap;
    lv  = 0;
    cap = 1;
    while (cap < n) begin
      cap = cap * radix;
      lv++;
    end
    return lv;
  endfunction

  function automatic int lvl_nodes(input int n, input int radix, input int k);
    int c;
    c = n;
    for (int i = 0; i < k; i++) c = (c + radix - 1) / radix;
    return c;
  endfunction

  // Bit offset of level k inside the flattened register vector holding levels 1..k-1.
  function automatic int lvl_off(input int n, input int radix, input int tbits, input int k);
    int off;
    off = 0;
    for (int i = 1; i < k; i++) off += lvl_nodes(n, radix, i) * (tbits + i * $clog2(radix));
    return off;
  endfunction

endpackage

// File: rtl/sq_sum_terms_pipe_node.sv
// One combinational Radix-input unsigned adder; output is wide enough that no
// operand combination can wrap.
module sq_sum_node #(
  parameter int Radix   = 4,
  parameter int InBits  = 8,
  parameter int OutBits = InBits + $clog2(Radix)
) (
  input  logic [InBits-1:0]  ops_i [Radix],
  output logic [OutBits-1:0] sum_o
);

  always_comb begin
    sum_o = '0;
    for (int r = 0; r < Radix; r++) sum_o = sum_o + OutBits'(ops_i[r]);
  end

endmodule

// File: rtl/sq_sum_terms_pipe.sv
// Pipelined multi-operand summer: registered radix tree, then a group accumulator.
// Result appears Levels+1 stages after a last beat; any held result stalls every stage.
module sq_sum_terms_pipe import msu_pkg::*; #(
  parameter int NumTerms = msu_pkg::SqGridRows,
  parameter int TermBits = msu_pkg::TreeBits,
  parameter int Radix    = 4,
  parameter int SumBits  = msu_pkg::SqSumBits
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [TermBits-1:0] terms_i [NumTerms],
  input  logic                last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [SumBits-1:0]  sum_o,
  output logic                ovf_o
);

  localparam int Levels  = tree_levels(NumTerms, Radix);
  localparam int LogR    = $clog2(Radix);
  localparam int TopBits = TermBits + Levels * LogR;
  localparam int TopOff  = lvl_off(NumTerms, Radix, TermBits, Levels);
  localparam int TreeW   = lvl_off(NumTerms, Radix, TermBits, Levels + 1);

  if (NumTerms < 2 || Radix < 2) begin : g_bad_param
    $error("sq_sum_terms_pipe: NumTerms and Radix must both be >= 2");
  end

  logic [TreeW-1:0]   tree_d, tree_q;
  logic [Levels:1]    vld_q, last_q;
  logic               open_q, open_d;
  logic               out_vld_q, out_vld_d;
  logic               ovf_q, ovf_d;
  logic [SumBits-1:0] acc_q, acc_d;
  logic               adv;

  assign adv        = !out_vld_q || out_ready_i;
  assign in_ready_o = adv;

  // Every level lives in one flat vector; level k nodes are TermBits+k*LogR wide.
  for (genvar k = 1; k <= Levels; k++) begin : g_lvl
    localparam int NIn    = lvl_nodes(NumTerms, Radix, k - 1);
    localparam int NOut   = lvl_nodes(NumTerms, Radix, k);
    localparam int WIn    = TermBits + (k - 1) * LogR;
    localparam int WOut   = WIn + LogR;
    localparam int OffIn  = lvl_off(NumTerms, Radix, TermBits, k - 1);
    localparam int OffOut = lvl_off(NumTerms, Radix, TermBits, k);
    for (genvar j = 0; j < NOut; j++) begin : g_node
      logic [WIn-1:0] ops [Radix];
      for (genvar r = 0; r < Radix; r++) begin : g_op
        localparam int Src = j * Radix + r;
        if (Src >= NIn) begin : g_pad
          assign ops[r] = '0;
        end else if (k == 1) begin : g_term
          assign ops[r] = terms_i[Src];
        end else begin : g_prev
          assign ops[r] = tree_q[OffIn + Src * WIn +: WIn];
        end
      end
      sq_sum_node #(.Radix(Radix), .InBits(WIn), .OutBits(WOut)) u_node (
        .ops_i (ops),
        .sum_o (tree_d[OffOut + j * WOut +: WOut])
      );
    end
  end

  always_ff @(posedge clk_i) begin
    if (adv) tree_q <= tree_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (adv) begin
      vld_q[1]  <= in_valid_i;
      last_q[1] <= last_i;
      for (int k = 2; k <= Levels; k++) begin
        vld_q[k]  <= vld_q[k-1];
        last_q[k] <= last_q[k-1];
      end
    end
  end

  logic [TopBits-1:0] top_res;
  logic [SumBits-1:0] top_lo;
  logic               top_big;
  logic [SumBits:0]   acc_sum;

  assign top_res = tree_q[TopOff +: TopBits];
  assign top_lo  = SumBits'(top_res);
  if (TopBits > SumBits) begin : g_top_wide
    assign top_big = |top_res[TopBits-1:SumBits];
  end else begin : g_top_narrow
    assign top_big = 1'b0;
  end
  assign acc_sum = {1'b0, acc_q} + {1'b0, top_lo};

  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    open_d    = open_q;
    out_vld_d = out_vld_q;
    if (adv) begin
      out_vld_d = 1'b0;
      if (vld_q[Levels]) begin
        if (open_q) begin
          acc_d = acc_sum[SumBits-1:0];
          ovf_d = ovf_q | acc_sum[SumBits] | top_big;
        end else begin
          acc_d = top_lo;
          ovf_d = top_big;
        end
        open_d    = !last_q[Levels];
        out_vld_d = last_q[Levels];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      open_q    <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      open_q    <= open_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign out_valid_o = out_vld_q;
  assign sum_o       = acc_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_sq_sum_terms_pipe.sv
// Bench for sq_sum_terms_pipe: two 16-term instances (16- and 12-bit sums) share stimulus,
// a 10-term radix-3 instance runs a random scoreboard.
module tb_sq_sum_terms_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic       a_in_valid, a_last, a_out_ready;
  logic [7:0] a_terms [16];
  logic       a_in_ready, a_out_valid, a_ovf;
  logic [15:0] a_sum;
  logic       c_in_ready, c_out_valid, c_ovf;
  logic [11:0] c_sum;

  logic       b_in_valid, b_last, b_out_ready;
  logic [7:0] b_terms [10];
  logic       b_in_ready, b_out_valid, b_ovf;
  logic [11:0] b_sum;

  sq_sum_terms_pipe #(.NumTerms(16), .TermBits(8), .Radix(4), .SumBits(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .terms_i(a_terms), .last_i(a_last), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .sum_o(a_sum), .ovf_o(a_ovf));

  sq_sum_terms_pipe #(.NumTerms(16), .TermBits(8), .Radix(4), .SumBits(12)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a_in_valid), .in_ready_o(c_in_ready),
    .terms_i(a_terms), .last_i(a_last), .out_valid_o(c_out_valid), .out_ready_i(a_out_ready),
    .sum_o(c_sum), .ovf_o(c_ovf));

  sq_sum_terms_pipe #(.NumTerms(10), .TermBits(8), .Radix(3), .SumBits(12)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .terms_i(b_terms), .last_i(b_last), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .sum_o(b_sum), .ovf_o(b_ovf));

  typedef struct {
    logic [15:0] sa;
    logic        oa;
    logic [11:0] sc;
    logic        oc;
  } exp_ac_t;

  typedef struct {
    logic [11:0] s;
    logic        o;
  } exp_b_t;

  typedef struct {
    logic [7:0]  base;
    bit          ramp;
    int          beats;
    logic [15:0] sa;
    logic        oa;
    logic [11:0] sc;
    logic        oc;
  } vec_t;

  exp_ac_t q_ac[$];
  exp_b_t  q_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Output-side scoreboard for the shared-stimulus pair.
  exp_ac_t mon_ac_e;
  always begin
    @(negedge clk);
    #2;
    if (rst_n && a_out_valid && a_out_ready) begin
      chk("ac_result_expected", (q_ac.size() != 0), 1'b1);
      if (q_ac.size() != 0) begin
        mon_ac_e = q_ac.pop_front();
        chk("a_sum", a_sum, mon_ac_e.sa);
        chk("a_ovf", a_ovf, mon_ac_e.oa);
        chk("c_valid", c_out_valid, 1'b1);
        chk("c_sum", c_sum, mon_ac_e.sc);
        chk("c_ovf", c_ovf, mon_ac_e.oc);
      end
    end
  end

  exp_b_t      mon_b_e;
  logic        b_prev_stall = 1'b0;
  logic [11:0] b_prev_sum;
  logic        b_prev_ovf;
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      chk("b_in_ready", b_in_ready, (!b_out_valid || b_out_ready));
      if (b_prev_stall) begin
        chk("b_hold_valid", b_out_valid, 1'b1);
        chk("b_hold_sum", b_sum, b_prev_sum);
        chk("b_hold_ovf", b_ovf, b_prev_ovf);
      end
      if (b_out_valid && b_out_ready) begin
        chk("b_result_expected", (q_b.size() != 0), 1'b1);
        if (q_b.size() != 0) begin
          mon_b_e = q_b.pop_front();
          chk("b_sum", b_sum, mon_b_e.s);
          chk("b_ovf", b_ovf, mon_b_e.o);
        end
      end
      b_prev_stall = b_out_valid && !b_out_ready;
      b_prev_sum   = b_sum;
      b_prev_ovf   = b_ovf;
    end else begin
      b_prev_stall = 1'b0;
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send_ac(input logic [7:0] base, input bit ramp, input bit last,
                         input bit push, input exp_ac_t e);
    int n;
    a_in_valid = 1'b1;
    a_last     = last;
    for (int i = 0; i < 16; i++) a_terms[i] = ramp ? 8'(i + 1) : base;
    #1;
    n = 0;
    while (!(a_in_ready && c_in_ready) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ac_beat_accepted", (a_in_ready && c_in_ready), 1'b1);
    if (push && a_in_ready && c_in_ready) q_ac.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain_ac();
    int n;
    n = 0;
    while ((q_ac.size() != 0 || a_out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ac_drained", q_ac.size(), 0);
    q_ac.delete();
  endtask

  vec_t    tbl[9];
  exp_ac_t e;
  exp_ac_t dummy;
  longint  grp;
  int      nb, cyc, n;

  initial begin
    tbl[0] = '{8'hFF, 1'b0, 1,  16'h0FF0, 1'b0, 12'hFF0, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 3,  16'd408,  1'b0, 12'd408,  1'b0};
    tbl[2] = '{8'hFF, 1'b0, 2,  16'h1FE0, 1'b0, 12'hFE0, 1'b1};
    tbl[3] = '{8'h01, 1'b0, 1,  16'd16,   1'b0, 12'd16,   1'b0};
    tbl[4] = '{8'h80, 1'b0, 1,  16'd2048, 1'b0, 12'd2048, 1'b0};
    tbl[5] = '{8'h80, 1'b0, 2,  16'h1000, 1'b0, 12'h000, 1'b1};
    tbl[6] = '{8'hFF, 1'b0, 5,  16'h4FB0, 1'b0, 12'hFB0, 1'b1};
    tbl[7] = '{8'h00, 1'b0, 2,  16'h0000, 1'b0, 12'h000, 1'b0};
    tbl[8] = '{8'hFF, 1'b0, 17, 16'h0EF0, 1'b1, 12'hEF0, 1'b1};
    dummy  = '{16'h0, 1'b0, 12'h0, 1'b0};

    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_last      = 1'b0;
    a_out_ready = 1'b0;
    b_in_valid  = 1'b0;
    b_last      = 1'b0;
    b_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) a_terms[i] = 8'h00;
    for (int i = 0; i < 10; i++) b_terms[i] = 8'h00;

    #12;
    chk("rst_a_valid", a_out_valid, 1'b0);
    chk("rst_a_sum", a_sum, 16'h0);
    chk("rst_a_ovf", a_ovf, 1'b0);
    chk("rst_a_in_ready", a_in_ready, 1'b1);
    chk("rst_b_valid", b_out_valid, 1'b0);
    chk("rst_b_in_ready", b_in_ready, 1'b1);
    @(negedge clk);
    #3 rst_n = 1'b1;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    @(negedge clk);

    // Latency of a single beat through the 16/4 tree: high after edge t+2.
    e = '{16'h0FF0, 1'b0, 12'hFF0, 1'b0};
    send_ac(8'hFF, 1'b0, 1'b1, 1'b1, e);
    a_in_valid = 1'b0;
    #2 chk("lat_a_t0", a_out_valid, 1'b0);
    @(negedge clk);
    #2 chk("lat_a_t1", a_out_valid, 1'b0);
    @(negedge clk);
    #2 chk("lat_a_t2", a_out_valid, 1'b1);
    @(negedge clk);
    drain_ac();

    foreach (tbl[v]) begin
      e = '{tbl[v].sa, tbl[v].oa, tbl[v].sc, tbl[v].oc};
      for (int b = 0; b < tbl[v].beats; b++)
        send_ac(tbl[v].base, tbl[v].ramp, (b == tbl[v].beats - 1), (b == tbl[v].beats - 1), e);
    end
    a_in_valid = 1'b0;
    drain_ac();

    // Back-pressure: results held for 5 cycles while the source keeps offering beats.
    @(negedge clk);
    a_out_ready = 1'b0;
    fork
      begin : bp_src
        exp_ac_t eb;
        for (int g = 0; g < 5; g++) begin
          eb = '{16'(16 * (g + 2)), 1'b0, 12'(16 * (g + 2)), 1'b0};
          send_ac(8'(g + 2), 1'b0, 1'b1, 1'b1, eb);
        end
        a_in_valid = 1'b0;
      end
      begin : bp_sink
        int w;
        w = 0;
        do begin
          @(negedge clk);
          #2;
          w++;
        end while (!a_out_valid && w < 50);
        chk("bp_valid_seen", a_out_valid, 1'b1);
        for (int s = 0; s < 5; s++) begin
          chk("bp_in_ready_low", a_in_ready, 1'b0);
          chk("bp_a_sum_held", a_sum, 16'd32);
          chk("bp_c_sum_held", c_sum, 12'd32);
          @(negedge clk);
          #2;
        end
        @(negedge clk);
        a_out_ready = 1'b1;
      end
    join
    drain_ac();

    // Reset while a 3-beat group is two beats in.
    send_ac(8'hFF, 1'b0, 1'b0, 1'b0, dummy);
    send_ac(8'hFF, 1'b0, 1'b0, 1'b0, dummy);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_a_valid", a_out_valid, 1'b0);
    chk("mid_rst_a_sum", a_sum, 16'h0);
    chk("mid_rst_a_ovf", a_ovf, 1'b0);
    chk("mid_rst_a_in_ready", a_in_ready, 1'b1);
    chk("mid_rst_c_valid", c_out_valid, 1'b0);
    chk("mid_rst_c_sum", c_sum, 12'h0);
    chk("mid_rst_c_in_ready", c_in_ready, 1'b1);
    @(negedge clk);
    #3 rst_n = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    e = '{16'd16, 1'b0, 12'd16, 1'b0};
    send_ac(8'h01, 1'b0, 1'b1, 1'b1, e);
    a_in_valid = 1'b0;
    drain_ac();

    // 10-term radix-3 instance: three tree levels, result high after edge t+3.
    b_in_valid = 1'b1;
    b_last     = 1'b1;
    for (int i = 0; i < 10; i++) b_terms[i] = 8'(i + 1);
    #1;
    chk("lat_b_accept", b_in_ready, 1'b1);
    q_b.push_back('{12'd55, 1'b0});
    @(negedge clk);
    b_in_valid = 1'b0;
    #2 chk("lat_b_t0", b_out_valid, 1'b0);
    @(negedge clk);
    #2 chk("lat_b_t1", b_out_valid, 1'b0);
    @(negedge clk);
    #2 chk("lat_b_t2", b_out_valid, 1'b0);
    @(negedge clk);
    #2 chk("lat_b_t3", b_out_valid, 1'b1);
    @(negedge clk);

    grp = 0;
    nb  = 0;
    cyc = 0;
    while (nb < 10000 && cyc < 80000) begin
      b_in_valid = ($urandom_range(0, 3) != 0);
      b_last     = b_in_valid && (nb == 9999 || $urandom_range(0, 2) == 0);
      for (int i = 0; i < 10; i++) b_terms[i] = 8'($urandom_range(0, 255));
      b_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (b_in_valid && b_in_ready) begin
        for (int i = 0; i < 10; i++) grp += longint'(b_terms[i]);
        nb++;
        if (b_last) begin
          q_b.push_back('{12'(grp), (grp > 4095)});
          grp = 0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("b_beats_sent", nb, 10000);
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    n = 0;
    while ((q_b.size() != 0 || b_out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("b_drained", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
